// File: rtl/hack_pkg.sv
// Shared state encodings, instruction field positions and decode helpers
// for the Hack CPU sequencer.
package hack_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEMRD  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef enum logic [2:0] {
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    MEMRD  = ST_MEMRD,
    EXEC   = ST_EXEC,
    ERR    = ST_ERR
  } state_t;

  localparam int unsigned IS_C    = 15;
  localparam int unsigned A_BIT   = 12;
  localparam int unsigned ALU_LSB = 6;
  localparam int unsigned D1      = 5;
  localparam int unsigned D2      = 4;
  localparam int unsigned D3      = 3;
  localparam int unsigned J1      = 2;
  localparam int unsigned J2      = 1;
  localparam int unsigned J3      = 0;

  function automatic logic is_c_instr(input logic [15:0] instr);
    return instr[IS_C];
  endfunction

endpackage

// File: rtl/hack_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the ROM/RAM ports (slave).
interface hack_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_data, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_data, dmem_ack
  );
endinterface

// File: rtl/hack_jump.sv
// Hack jump condition: j = {j1,j2,j3} selects <0, =0, >0 on the ALU flags.
module hack_jump (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);
  import hack_pkg::*;

  // Jump if any selected comparison holds for the current ALU result
  always_comb begin
    jump = (j[J1] & ng) | (j[J2] & zr) | (j[J3] & ~ng & ~zr);
  end
endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle sequencer for the Hack CPU datapath: fetches over a req/ack
// handshake, decodes A/C instructions and drives datapath strobes plus the
// data-memory handshake. A ack-wait watchdog parks the FSM in ERR.
module hack_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  hack_ctrl_if.master      bus,
  output logic [15:0]      ir,
  output logic [5:0]       alu_ctl,
  output logic             y_sel_m,
  output logic             m_latch,
  output logic             a_load,
  output logic             a_sel_imm,
  output logic             d_load,
  output logic             pc_load,
  output logic             pc_inc,
  input  logic             zr,
  input  logic             ng,
  output logic             err,
  output logic             idle
);
  import hack_pkg::*;

  state_t      state, state_d;
  logic [31:0] wait_cnt;
  logic        waiting;
  logic        fetch_done;
  logic        jump;

  hack_jump u_jump (
    .j    (ir[J1:J3]),
    .zr   (zr),
    .ng   (ng),
    .jump (jump)
  );

  // Next state and all strobes/requests, decoded from state, ir, acks, flags
  always_comb begin
    state_d    = state;
    waiting    = 1'b0;
    fetch_done = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    alu_ctl    = '0;
    y_sel_m    = 1'b0;
    m_latch    = 1'b0;
    a_load     = 1'b0;
    a_sel_imm  = 1'b0;
    d_load     = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    unique case (state)
      FETCH: begin
        bus.imem_req = run;
        waiting      = run & ~bus.imem_ack;
        if (run && bus.imem_ack) begin
          fetch_done = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (!is_c_instr(ir)) begin
          a_load    = 1'b1;
          a_sel_imm = 1'b1;
          pc_inc    = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = ir[A_BIT] ? MEMRD : EXEC;
        end
      end
      MEMRD: begin
        bus.dmem_req = 1'b1;
        waiting      = ~bus.dmem_ack;
        if (bus.dmem_ack) begin
          m_latch = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_ctl = ir[ALU_LSB +: 6];
        y_sel_m = ir[A_BIT];
        // M writes hold the commit until the RAM acknowledges
        if (!ir[D3] || bus.dmem_ack) begin
          a_load  = ir[D1];
          d_load  = ir[D2];
          pc_load = jump;
          pc_inc  = ~jump;
          state_d = FETCH;
        end
        if (ir[D3]) begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = 1'b1;
          waiting      = ~bus.dmem_ack;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = FETCH;
    endcase

    if (ACK_TIMEOUT != 0 && waiting && wait_cnt == ACK_TIMEOUT - 1)
      state_d = ERR;

    if (rst) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      m_latch    = 1'b0;
      a_load     = 1'b0;
      a_sel_imm  = 1'b0;
      d_load     = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      fetch_done = 1'b0;
    end
  end

  // State, instruction register and ack-wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_d;
      if (fetch_done)
        ir <= bus.imem_data;
      if (state_d != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Status flags
  always_comb begin
    err  = (state == ERR) && !rst;
    idle = (state == FETCH) && !run;
  end
endmodule

// File: tb/tb_hack_ctrl.sv
// Directed self-checking bench for the Hack sequencer.
module tb_hack_ctrl;
  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] ir;
  logic [5:0]  alu_ctl;
  logic        y_sel_m, m_latch, a_load, a_sel_imm, d_load, pc_load, pc_inc;
  logic        zr, ng, err, idle;
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned m_latch_cnt;

  hack_ctrl_if bus ();

  hack_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus),
    .ir        (ir),
    .alu_ctl   (alu_ctl),
    .y_sel_m   (y_sel_m),
    .m_latch   (m_latch),
    .a_load    (a_load),
    .a_sel_imm (a_sel_imm),
    .d_load    (d_load),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .zr        (zr),
    .ng        (ng),
    .err       (err),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {imem_req,dmem_req,dmem_we,m_latch,a_load,a_sel_imm,d_load,pc_load,pc_inc}
  function automatic logic [8:0] strobes();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, m_latch, a_load,
            a_sel_imm, d_load, pc_load, pc_inc};
  endfunction

  // From FETCH: present the word with a zero-wait ack; returns in DECODE
  task automatic fetch(input logic [15:0] word);
    bus.imem_data = word;
    bus.imem_ack  = 1'b1;
    #1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
  endtask

  // dmem_ack and expected {dmem_req,dmem_we,m_latch,y_sel_m,pc_inc} per cycle
  logic       mw_ack [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [4:0] mw_exp [5] = '{5'b10000, 5'b10000, 5'b10100, 5'b11010, 5'b11011};

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_latch_cnt = 0;
    rst = 1'b1;
    run = 1'b1;
    zr = 1'b0;
    ng = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h0000;
    bus.dmem_ack  = 1'b0;

    // Reset with a stray ack present
    tick();
    tick();
    chk("rst_strobes", {23'd0, strobes()}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'h0);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);

    // A-instruction @5
    fetch(16'h0005);
    chk("a_ir", {16'd0, ir}, 32'h0005);
    chk("a_decode", {23'd0, strobes()}, 32'b000011001);
    tick();
    chk("a_back_fetch", {31'd0, bus.imem_req}, 32'd1);

    // D=A
    fetch(16'hEC10);
    chk("dA_decode", {23'd0, strobes()}, 32'h0);
    tick();
    chk("dA_alu", {26'd0, alu_ctl}, 32'b110000);
    chk("dA_exec", {23'd0, strobes()}, 32'b000000101);
    chk("dA_ysel", {31'd0, y_sel_m}, 32'd0);
    tick();
    chk("dA_back_fetch", {31'd0, bus.imem_req}, 32'd1);

    // M=M-1: read ack in 3rd cycle, write ack in 2nd cycle
    fetch(16'hFC88);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.dmem_ack = mw_ack[i];
      #1;
      if (m_latch) m_latch_cnt++;
      chk($sformatf("mw_cyc%0d", i),
          {27'd0, bus.dmem_req, bus.dmem_we, m_latch, y_sel_m, pc_inc},
          {27'd0, mw_exp[i]});
      if (i >= 3) chk($sformatf("mw_alu%0d", i), {26'd0, alu_ctl}, 32'b110010);
      if (i == 4) chk("mw_commit", {29'd0, a_load, d_load, pc_load}, 32'd0);
      tick();
    end
    bus.dmem_ack = 1'b0;
    #1;
    chk("mw_mlatch_once", m_latch_cnt, 32'd1);
    chk("mw_back_fetch", {23'd0, strobes()}, 32'b100000000);

    // D;JEQ
    fetch(16'hE302);
    tick();
    zr = 1'b1; ng = 1'b0;
    #1;
    chk("jeq_taken", {30'd0, pc_load, pc_inc}, 32'b10);
    zr = 1'b0; ng = 1'b1;
    #1;
    chk("jeq_neg", {30'd0, pc_load, pc_inc}, 32'b01);
    zr = 1'b0; ng = 1'b0;
    #1;
    chk("jeq_pos", {30'd0, pc_load, pc_inc}, 32'b01);
    tick();
    zr = 1'b0;

    // run dropped mid-instruction: instruction completes, then idle
    fetch(16'h0007);
    run = 1'b0;
    #1;
    chk("stop_decode", {23'd0, strobes()}, 32'b000011001);
    tick();
    chk("stop_idle", {30'd0, idle, bus.imem_req}, 32'b10);
    for (int i = 0; i < 6; i++) tick();
    chk("stop_no_err", {30'd0, err, idle}, 32'b01);

    // Fetch watchdog with ACK_TIMEOUT=4
    run = 1'b1;
    #1;
    tick();
    tick();
    tick();
    chk("to_before", {30'd0, err, bus.imem_req}, 32'b01);
    tick();
    chk("to_err", {30'd0, err, bus.imem_req}, 32'b10);
    bus.imem_ack = 1'b1;
    tick();
    tick();
    chk("to_sticky", {22'd0, err, strobes()}, 32'h200);
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    tick();
    chk("to_rst", {22'd0, err, strobes()}, 32'h0);
    rst = 1'b0;
    #1;
    chk("to_recover", {30'd0, err, bus.imem_req}, 32'b01);

    // Reset in the middle of a data read drops dmem_req
    fetch(16'hFC10);
    tick();
    chk("mr_req", {31'd0, bus.dmem_req}, 32'd1);
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    tick();
    chk("mr_rst_drop", {23'd0, strobes()}, 32'h0);
    rst = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    chk("mr_fetch", {23'd0, strobes()}, 32'b100000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
